// File: rtl/issue_queue.sv
// In-order issue queue: buffers decoded instructions, resolves their operands
// from the register file / ROB / CDB and dispatches one per cycle to the RS or LSB.
module issue_queue #(
    parameter int DATA_W = 32,
    parameter int ROB_W  = 4,
    parameter int OP_W   = 6,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [DATA_W-1:0] in_pc,
    input  logic              in_is_mem,
    input  logic              in_has_rd,
    input  logic              in_pred_jump,
    output logic [4:0]        out_reg_rs1,
    output logic [4:0]        out_reg_rs2,
    input  logic [DATA_W-1:0] in_reg_val1,
    input  logic [DATA_W-1:0] in_reg_val2,
    input  logic [ROB_W-1:0]  in_reg_tag1,
    input  logic [ROB_W-1:0]  in_reg_tag2,
    input  logic              in_reg_busy1,
    input  logic              in_reg_busy2,
    output logic [ROB_W-1:0]  out_rob_q1,
    output logic [ROB_W-1:0]  out_rob_q2,
    input  logic              in_rob_rdy1,
    input  logic              in_rob_rdy2,
    input  logic [DATA_W-1:0] in_rob_val1,
    input  logic [DATA_W-1:0] in_rob_val2,
    input  logic              in_rob_full,
    input  logic [ROB_W-1:0]  in_rob_freetag,
    input  logic              in_cdb_valid,
    input  logic [ROB_W-1:0]  in_cdb_tag,
    input  logic [DATA_W-1:0] in_cdb_val,
    input  logic              in_rs_full,
    input  logic              in_lsb_full,
    output logic              out_valid,
    output logic              out_to_lsb,
    output logic [OP_W-1:0]   out_op,
    output logic [4:0]        out_rd,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_imm,
    output logic [DATA_W-1:0] out_v1,
    output logic [DATA_W-1:0] out_v2,
    output logic [ROB_W-1:0]  out_q1,
    output logic [ROB_W-1:0]  out_q2,
    output logic [ROB_W-1:0]  out_rob_tag,
    output logic              out_pred_jump,
    output logic              out_rename_valid
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [4:0]        rd;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc;
        logic              is_mem;
        logic              has_rd;
        logic              pred_jump;
    } entry_t;

    entry_t            slots [DEPTH];
    entry_t            head_entry;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic              do_enq;
    logic              do_deq;
    logic              unit_full;
    logic [ROB_W+DATA_W-1:0] opnd1;
    logic [ROB_W+DATA_W-1:0] opnd2;

    // Returns {q, v}: a zero tag means the value is final.
    function automatic logic [ROB_W+DATA_W-1:0] resolve(
        input logic [4:0]        rs,
        input logic              busy,
        input logic [DATA_W-1:0] reg_val,
        input logic [ROB_W-1:0]  tag,
        input logic              rob_rdy,
        input logic [DATA_W-1:0] rob_val,
        input logic              cdb_valid,
        input logic [ROB_W-1:0]  cdb_tag,
        input logic [DATA_W-1:0] cdb_val
    );
        if (rs == 5'd0)
            return '0;
        else if (!busy)
            return {{ROB_W{1'b0}}, reg_val};
        else if (rob_rdy)
            return {{ROB_W{1'b0}}, rob_val};
        else if (cdb_valid && cdb_tag == tag)
            return {{ROB_W{1'b0}}, cdb_val};
        else
            return {tag, {DATA_W{1'b0}}};
    endfunction

    assign head_entry  = slots[head];
    assign in_ready    = (count < FULL_COUNT);
    assign out_reg_rs1 = head_entry.rs1;
    assign out_reg_rs2 = head_entry.rs2;
    assign out_rob_q1  = in_reg_tag1;
    assign out_rob_q2  = in_reg_tag2;

    assign unit_full = head_entry.is_mem ? in_lsb_full : in_rs_full;
    assign do_enq    = in_valid && in_ready && rdy && !flush;
    assign do_deq    = (count != '0) && rdy && !flush && !in_rob_full && !unit_full;

    assign opnd1 = resolve(head_entry.rs1, in_reg_busy1, in_reg_val1, in_reg_tag1,
                           in_rob_rdy1, in_rob_val1, in_cdb_valid, in_cdb_tag, in_cdb_val);
    assign opnd2 = resolve(head_entry.rs2, in_reg_busy2, in_reg_val2, in_reg_tag2,
                           in_rob_rdy2, in_rob_val2, in_cdb_valid, in_cdb_tag, in_cdb_val);

    // Entry storage carries no reset; occupancy is tracked solely by count.
    always_ff @(posedge clk) begin
        if (do_enq && !rst) begin
            slots[tail] <= '{op: in_op, rd: in_rd, rs1: in_rs1, rs2: in_rs2, imm: in_imm,
                             pc: in_pc, is_mem: in_is_mem, has_rd: in_has_rd,
                             pred_jump: in_pred_jump};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            out_valid        <= 1'b0;
            out_to_lsb       <= 1'b0;
            out_op           <= '0;
            out_rd           <= '0;
            out_pc           <= '0;
            out_imm          <= '0;
            out_v1           <= '0;
            out_v2           <= '0;
            out_q1           <= '0;
            out_q2           <= '0;
            out_rob_tag      <= '0;
            out_pred_jump    <= 1'b0;
            out_rename_valid <= 1'b0;
        end else if (flush) begin
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            out_valid        <= 1'b0;
            out_rename_valid <= 1'b0;
        end else begin
            if (do_enq)
                tail <= tail + PTR_W'(1);
            if (do_deq)
                head <= head + PTR_W'(1);
            if (do_enq && !do_deq)
                count <= count + CNT_W'(1);
            else if (!do_enq && do_deq)
                count <= count - CNT_W'(1);

            out_valid        <= do_deq;
            out_rename_valid <= do_deq && head_entry.has_rd && (head_entry.rd != 5'd0);
            // Payload registers hold their last dispatched value between dispatches.
            if (do_deq) begin
                out_to_lsb    <= head_entry.is_mem;
                out_op        <= head_entry.op;
                out_rd        <= head_entry.rd;
                out_pc        <= head_entry.pc;
                out_imm       <= head_entry.imm;
                out_v1        <= opnd1[DATA_W-1:0];
                out_q1        <= opnd1[ROB_W+DATA_W-1:DATA_W];
                out_v2        <= opnd2[DATA_W-1:0];
                out_q2        <= opnd2[ROB_W+DATA_W-1:DATA_W];
                out_rob_tag   <= in_rob_freetag;
                out_pred_jump <= head_entry.pred_jump;
            end
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Scenario-based bench for issue_queue; expected dispatches are queued at
// enqueue time and compared as the DUT emits them.
module tb_issue_queue;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_op;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic [31:0] in_pc;
    logic        in_is_mem;
    logic        in_has_rd;
    logic        in_pred_jump;
    logic [4:0]  out_reg_rs1;
    logic [4:0]  out_reg_rs2;
    logic [31:0] in_reg_val1;
    logic [31:0] in_reg_val2;
    logic [3:0]  in_reg_tag1;
    logic [3:0]  in_reg_tag2;
    logic        in_reg_busy1;
    logic        in_reg_busy2;
    logic [3:0]  out_rob_q1;
    logic [3:0]  out_rob_q2;
    logic        in_rob_rdy1;
    logic        in_rob_rdy2;
    logic [31:0] in_rob_val1;
    logic [31:0] in_rob_val2;
    logic        in_rob_full;
    logic [3:0]  in_rob_freetag;
    logic        in_cdb_valid;
    logic [3:0]  in_cdb_tag;
    logic [31:0] in_cdb_val;
    logic        in_rs_full;
    logic        in_lsb_full;
    logic        out_valid;
    logic        out_to_lsb;
    logic [5:0]  out_op;
    logic [4:0]  out_rd;
    logic [31:0] out_pc;
    logic [31:0] out_imm;
    logic [31:0] out_v1;
    logic [31:0] out_v2;
    logic [3:0]  out_q1;
    logic [3:0]  out_q2;
    logic [3:0]  out_rob_tag;
    logic        out_pred_jump;
    logic        out_rename_valid;

    typedef struct packed {
        logic        to_lsb;
        logic [5:0]  op;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] v1;
        logic [3:0]  q1;
        logic [31:0] v2;
        logic [3:0]  q2;
        logic [3:0]  rob_tag;
        logic        pred_jump;
        logic        rename_valid;
    } disp_t;

    disp_t sb[$];
    int    checks;
    int    errors;

    issue_queue #(.DATA_W(32), .ROB_W(4), .OP_W(6), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_pc(in_pc),
        .in_is_mem(in_is_mem), .in_has_rd(in_has_rd), .in_pred_jump(in_pred_jump),
        .out_reg_rs1(out_reg_rs1), .out_reg_rs2(out_reg_rs2),
        .in_reg_val1(in_reg_val1), .in_reg_val2(in_reg_val2),
        .in_reg_tag1(in_reg_tag1), .in_reg_tag2(in_reg_tag2),
        .in_reg_busy1(in_reg_busy1), .in_reg_busy2(in_reg_busy2),
        .out_rob_q1(out_rob_q1), .out_rob_q2(out_rob_q2),
        .in_rob_rdy1(in_rob_rdy1), .in_rob_rdy2(in_rob_rdy2),
        .in_rob_val1(in_rob_val1), .in_rob_val2(in_rob_val2),
        .in_rob_full(in_rob_full), .in_rob_freetag(in_rob_freetag),
        .in_cdb_valid(in_cdb_valid), .in_cdb_tag(in_cdb_tag), .in_cdb_val(in_cdb_val),
        .in_rs_full(in_rs_full), .in_lsb_full(in_lsb_full),
        .out_valid(out_valid), .out_to_lsb(out_to_lsb), .out_op(out_op), .out_rd(out_rd),
        .out_pc(out_pc), .out_imm(out_imm), .out_v1(out_v1), .out_v2(out_v2),
        .out_q1(out_q1), .out_q2(out_q2), .out_rob_tag(out_rob_tag),
        .out_pred_jump(out_pred_jump), .out_rename_valid(out_rename_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic disp_t get_obs();
        disp_t o;
        o.to_lsb       = out_to_lsb;
        o.op           = out_op;
        o.rd           = out_rd;
        o.pc           = out_pc;
        o.imm          = out_imm;
        o.v1           = out_v1;
        o.q1           = out_q1;
        o.v2           = out_v2;
        o.q2           = out_q2;
        o.rob_tag      = out_rob_tag;
        o.pred_jump    = out_pred_jump;
        o.rename_valid = out_rename_valid;
        return o;
    endfunction

    // Drives one fetch beat; when push is set the matching dispatch is expected later.
    task automatic send(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic is_mem, input logic has_rd,
                        input logic pj, input logic [31:0] ev1, input logic [3:0] eq1,
                        input logic [31:0] ev2, input logic [3:0] eq2, input bit push);
        disp_t e;
        in_valid     = 1'b1;
        in_op        = op;
        in_rd        = rd;
        in_rs1       = rs1;
        in_rs2       = rs2;
        in_pc        = 32'h1000 + {24'h0, op, 2'b00};
        in_imm       = {26'h0, op} ^ 32'hA5A5_0000;
        in_is_mem    = is_mem;
        in_has_rd    = has_rd;
        in_pred_jump = pj;
        if (push) begin
            e.to_lsb       = is_mem;
            e.op           = op;
            e.rd           = rd;
            e.pc           = 32'h1000 + {24'h0, op, 2'b00};
            e.imm          = {26'h0, op} ^ 32'hA5A5_0000;
            e.v1           = ev1;
            e.q1           = eq1;
            e.v2           = ev2;
            e.q2           = eq2;
            e.rob_tag      = in_rob_freetag;
            e.pred_jump    = pj;
            e.rename_valid = has_rd && (rd != 5'd0);
            sb.push_back(e);
        end
    endtask

    task automatic set_plain_regs();
        in_reg_busy1 = 1'b0;
        in_reg_busy2 = 1'b0;
        in_reg_val1  = 32'h100;
        in_reg_val2  = 32'h200;
        in_reg_tag1  = 4'd0;
        in_reg_tag2  = 4'd0;
        in_rob_rdy1  = 1'b0;
        in_rob_rdy2  = 1'b0;
        in_cdb_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready);
        end
        checks++;
        if (get_obs() !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h want 0", get_obs());
        end
        rst = 1'b0;
    endtask

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        busy;
        logic [31:0] reg_val;
        logic [3:0]  tag;
        logic        rob_rdy;
        logic [31:0] rob_val;
        logic        cdb_v;
        logic [3:0]  cdb_tag;
        logic [31:0] cdb_val;
        logic [31:0] ev1;
        logic [3:0]  eq1;
        logic [31:0] ev2;
        logic [3:0]  eq2;
    } opcase_t;

    task automatic test_operands();
        opcase_t cs [6];
        disp_t   want;
        cs[0] = '{5'd1, 5'd0, 1'b0, 32'h11,   4'd0, 1'b0, 32'h0,    1'b0, 4'd0, 32'h0,
                  32'h11,   4'd0, 32'h0,    4'd0};
        cs[1] = '{5'd2, 5'd3, 1'b1, 32'hDEAD, 4'd5, 1'b0, 32'h1234, 1'b1, 4'd5, 32'hABCD,
                  32'hABCD, 4'd0, 32'hABCD, 4'd0};
        cs[2] = '{5'd2, 5'd3, 1'b1, 32'hDEAD, 4'd5, 1'b0, 32'h1234, 1'b1, 4'd6, 32'hABCD,
                  32'h0,    4'd5, 32'h0,    4'd5};
        cs[3] = '{5'd4, 5'd5, 1'b1, 32'hDEAD, 4'd4, 1'b1, 32'h77,   1'b1, 4'd4, 32'h99,
                  32'h77,   4'd0, 32'h77,   4'd0};
        cs[4] = '{5'd0, 5'd9, 1'b1, 32'hDEAD, 4'd7, 1'b0, 32'h1234, 1'b0, 4'd7, 32'h99,
                  32'h0,    4'd0, 32'h0,    4'd7};
        cs[5] = '{5'd6, 5'd7, 1'b0, 32'h55,   4'd2, 1'b1, 32'h66,   1'b1, 4'd2, 32'h99,
                  32'h55,   4'd0, 32'h55,   4'd0};
        for (int i = 0; i < 6; i++) begin
            in_reg_busy1   = cs[i].busy;
            in_reg_busy2   = cs[i].busy;
            in_reg_val1    = cs[i].reg_val;
            in_reg_val2    = cs[i].reg_val;
            in_reg_tag1    = cs[i].tag;
            in_reg_tag2    = cs[i].tag;
            in_rob_rdy1    = cs[i].rob_rdy;
            in_rob_rdy2    = cs[i].rob_rdy;
            in_rob_val1    = cs[i].rob_val;
            in_rob_val2    = cs[i].rob_val;
            in_cdb_valid   = cs[i].cdb_v;
            in_cdb_tag     = cs[i].cdb_tag;
            in_cdb_val     = cs[i].cdb_val;
            in_rob_freetag = 4'(i + 1);
            send(6'(10 + i), 5'(i + 1), cs[i].rs1, cs[i].rs2, 1'b0, 1'b1, i[0],
                 cs[i].ev1, cs[i].eq1, cs[i].ev2, cs[i].eq2, 1'b1);
            step();
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b0 || out_reg_rs1 !== cs[i].rs1 || out_rob_q1 !== cs[i].tag) begin
                errors++;
                $display("[TB] FAIL operands_enq[%0d]: got valid=%b rs1=%0d q=%0d want valid=0 rs1=%0d q=%0d",
                         i, out_valid, out_reg_rs1, out_rob_q1, cs[i].rs1, cs[i].tag);
            end
            step();
            checks++;
            if (out_valid !== 1'b1 || sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL operands_valid[%0d]: got %b want 1 (pending %0d)", i, out_valid, sb.size());
            end else begin
                want = sb.pop_front();
                checks++;
                if (get_obs() !== want) begin
                    errors++;
                    $display("[TB] FAIL operands_data[%0d]: got %h want %h", i, get_obs(), want);
                end
            end
        end
    endtask

    task automatic test_full();
        disp_t want;
        set_plain_regs();
        in_rob_full    = 1'b1;
        in_rob_freetag = 4'd9;
        for (int i = 0; i < 4; i++) begin
            send(6'(20 + i), 5'(8 + i), 5'(i + 1), 5'd2, (i == 2), 1'b1, 1'b0,
                 32'h100, 4'd0, 32'h200, 4'd0, 1'b1);
            step();
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_ready: got %b want 0", in_ready);
        end
        send(6'd30, 5'd12, 5'd3, 5'd4, 1'b0, 1'b1, 1'b1, 32'h100, 4'd0, 32'h200, 4'd0, 1'b0);
        step();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_hold: got ready=%b valid=%b want 0 0", in_ready, out_valid);
        end
        in_rob_full = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL full_drain_valid[%0d]: got %b want 1 (pending %0d)", k, out_valid, sb.size());
            end else begin
                want = sb.pop_front();
                checks++;
                if (get_obs() !== want) begin
                    errors++;
                    $display("[TB] FAIL full_drain_data[%0d]: got %h want %h", k, get_obs(), want);
                end
            end
            if (k == 0) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL full_ready_rise: got %b want 1", in_ready);
                end
                send(6'd30, 5'd12, 5'd3, 5'd4, 1'b0, 1'b1, 1'b1, 32'h100, 4'd0, 32'h200, 4'd0, 1'b1);
            end
            if (k == 1)
                in_valid = 1'b0;
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL full_drain_end: got valid=%b pending=%0d want 0 0", out_valid, sb.size());
        end
    endtask

    task automatic test_lsb_hol();
        disp_t want;
        set_plain_regs();
        in_rob_freetag = 4'd6;
        in_lsb_full    = 1'b1;
        in_rs_full     = 1'b0;
        send(6'd40, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 32'h100, 4'd0, 32'h200, 4'd0, 1'b1);
        step();
        send(6'd41, 5'd3, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 32'h100, 4'd0, 32'h200, 4'd0, 1'b1);
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL lsb_block[%0d]: got %b want 0", k, out_valid);
            end
        end
        in_lsb_full = 1'b0;
        in_rs_full  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k == 2)
                in_rs_full = 1'b0;
            step();
            checks++;
            if (out_valid !== (k != 1)) begin
                errors++;
                $display("[TB] FAIL lsb_order_valid[%0d]: got %b want %b", k, out_valid, (k != 1));
            end else if (out_valid) begin
                want = sb.pop_front();
                checks++;
                if (get_obs() !== want || out_to_lsb !== (k == 0)) begin
                    errors++;
                    $display("[TB] FAIL lsb_order_data[%0d]: got %h want %h", k, get_obs(), want);
                end
            end
        end
    endtask

    task automatic test_flush();
        disp_t want;
        set_plain_regs();
        in_rob_full    = 1'b1;
        in_rob_freetag = 4'd2;
        for (int i = 0; i < 3; i++) begin
            send(6'(50 + i), 5'd4, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 32'h100, 4'd0, 32'h200, 4'd0, 1'b0);
            step();
        end
        send(6'd53, 5'd4, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 32'h100, 4'd0, 32'h200, 4'd0, 1'b0);
        flush = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flush_state: got valid=%b ready=%b want 0 1", out_valid, in_ready);
        end
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_rob_full = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL flush_empty[%0d]: got %b want 0", k, out_valid);
            end
        end
        send(6'd54, 5'd5, 5'd1, 5'd2, 1'b0, 1'b1, 1'b1, 32'h100, 4'd0, 32'h200, 4'd0, 1'b1);
        step();
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL flush_restart_valid: got %b want 1", out_valid);
        end else begin
            want = sb.pop_front();
            checks++;
            if (get_obs() !== want) begin
                errors++;
                $display("[TB] FAIL flush_restart_data: got %h want %h", get_obs(), want);
            end
        end
        send(6'd55, 5'd5, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 32'h100, 4'd0, 32'h200, 4'd0, 1'b0);
        step();
        in_valid = 1'b0;
        flush    = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_over_dispatch: got %b want 0", out_valid);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_cleared: got %b want 0", out_valid);
        end
    endtask

    task automatic test_rename();
        logic       mems [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic       hrds [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [4:0] rds  [4] = '{5'd0, 5'd0, 5'd5, 5'd7};
        logic [3:0] tags [4] = '{4'd1, 4'd2, 4'd4, 4'd3};
        logic       exps [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        disp_t      want;
        set_plain_regs();
        for (int i = 0; i < 4; i++) begin
            in_rob_freetag = tags[i];
            send(6'(60 + i), rds[i], 5'd1, 5'd2, mems[i], hrds[i], 1'b0,
                 32'h100, 4'd0, 32'h200, 4'd0, 1'b1);
            step();
            in_valid = 1'b0;
            step();
            checks++;
            if (out_valid !== 1'b1 || out_rename_valid !== exps[i] || out_rob_tag !== tags[i]) begin
                errors++;
                $display("[TB] FAIL rename[%0d]: got valid=%b rename=%b tag=%0d want 1 %b %0d",
                         i, out_valid, out_rename_valid, out_rob_tag, exps[i], tags[i]);
            end
            if (sb.size() != 0) begin
                want = sb.pop_front();
                checks++;
                if (get_obs() !== want) begin
                    errors++;
                    $display("[TB] FAIL rename_data[%0d]: got %h want %h", i, get_obs(), want);
                end
            end
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || out_rename_valid !== 1'b0 || out_rob_tag !== 4'd3) begin
            errors++;
            $display("[TB] FAIL rename_idle: got valid=%b rename=%b tag=%0d want 0 0 3",
                     out_valid, out_rename_valid, out_rob_tag);
        end
    endtask

    task automatic test_rdy();
        disp_t want;
        set_plain_regs();
        in_rob_full    = 1'b1;
        in_rob_freetag = 4'd11;
        send(6'd70, 5'd9, 5'd1, 5'd2, 1'b0, 1'b1, 1'b1, 32'h100, 4'd0, 32'h200, 4'd0, 1'b1);
        step();
        rdy         = 1'b0;
        in_rob_full = 1'b0;
        send(6'd71, 5'd9, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 32'h100, 4'd0, 32'h200, 4'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL rdy_frozen[%0d]: got %b want 0", k, out_valid);
            end
        end
        in_valid = 1'b0;
        rdy      = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL rdy_resume_valid: got %b want 1", out_valid);
        end else begin
            want = sb.pop_front();
            checks++;
            if (get_obs() !== want) begin
                errors++;
                $display("[TB] FAIL rdy_resume_data: got %h want %h", get_obs(), want);
            end
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rdy_no_capture: got %b want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        set_plain_regs();
        in_rob_full = 1'b1;
        for (int i = 0; i < 2; i++) begin
            send(6'(80 + i), 5'd3, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 32'h100, 4'd0, 32'h200, 4'd0, 1'b0);
            step();
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        flush    = 1'b1;
        step();
        checks++;
        if (get_obs() !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_mid_outputs: got %h valid=%b ready=%b want 0 0 1",
                     get_obs(), out_valid, in_ready);
        end
        rst         = 1'b0;
        flush       = 1'b0;
        in_rob_full = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_mid_discard[%0d]: got %b want 0", k, out_valid);
            end
        end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        rdy            = 1'b1;
        flush          = 1'b0;
        in_valid       = 1'b0;
        in_op          = '0;
        in_rd          = '0;
        in_rs1         = '0;
        in_rs2         = '0;
        in_imm         = '0;
        in_pc          = '0;
        in_is_mem      = 1'b0;
        in_has_rd      = 1'b0;
        in_pred_jump   = 1'b0;
        in_rob_val1    = '0;
        in_rob_val2    = '0;
        in_rob_full    = 1'b0;
        in_rob_freetag = '0;
        in_cdb_tag     = '0;
        in_cdb_val     = '0;
        in_rs_full     = 1'b0;
        in_lsb_full    = 1'b0;
        set_plain_regs();

        test_reset();
        test_operands();
        test_full();
        test_lsb_hol();
        test_flush();
        test_rename();
        test_rdy();
        test_reset_mid();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_leftover: got %0d pending want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
